// File: rtl/cordic_result_unpack.sv
//----------------------------------------------------------------------------
// cordic_result_unpack
// Collects LSB-first serial x/y/z CORDIC results into WIDTH-bit words and
// presents them through a 2-entry valid/ready queue.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module cordic_result_unpack #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             xi,
    input  logic             yi,
    input  logic             zi,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overflow
);

    localparam int             CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);
    localparam logic [1:0]     C_FULL = 2'd2;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sr_x, r_sr_y, r_sr_z;
    logic [WIDTH-1:0] r_qx [2];
    logic [WIDTH-1:0] r_qy [2];
    logic [WIDTH-1:0] r_qz [2];
    logic             r_wptr, r_rptr;
    logic [1:0]       r_count;
    logic             r_frame_err;
    logic             r_overflow;

    logic [WIDTH-1:0] w_word_x, w_word_y, w_word_z;
    logic             w_done, w_pop, w_push, w_valid;

    assign w_word_x = {xi, r_sr_x[WIDTH-1:1]};
    assign w_word_y = {yi, r_sr_y[WIDTH-1:1]};
    assign w_word_z = {zi, r_sr_z[WIDTH-1:1]};

    assign w_valid  = (r_count != 2'd0);
    assign w_done   = valid_i && (r_cnt == C_LAST);
    assign w_pop    = w_valid && out_ready;
    // A full queue can still take a word when the head leaves in the same cycle.
    assign w_push   = w_done && ((r_count != C_FULL) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_sr_x      <= '0;
            r_sr_y      <= '0;
            r_sr_z      <= '0;
            for (int i = 0; i < 2; i++) begin
                r_qx[i] <= '0;
                r_qy[i] <= '0;
                r_qz[i] <= '0;
            end
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (valid_i) begin
                r_sr_x <= w_word_x;
                r_sr_y <= w_word_y;
                r_sr_z <= w_word_z;
                r_cnt  <= w_done ? '0 : r_cnt + CW'(1);
            end else begin
                r_cnt  <= '0;
            end

            // Strobe dropped part-way through a word.
            r_frame_err <= !valid_i && (r_cnt != '0);

            if (w_push) begin
                r_qx[r_wptr] <= w_word_x;
                r_qy[r_wptr] <= w_word_y;
                r_qz[r_wptr] <= w_word_z;
                r_wptr       <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            if (w_done && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign x_out     = r_qx[r_rptr];
    assign y_out     = r_qy[r_rptr];
    assign z_out     = r_qz[r_rptr];
    assign out_valid = w_valid;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: doc/cordic_result_unpack.md
# cordic_result_unpack

Bit-serial to parallel result collector for the serial CORDIC engine. It samples the engine's LSB-first serial outputs (x, y, z) during each `valid` frame, assembles the bits into WIDTH-bit words, and buffers them in a 2-entry queue. Parallel consumers read the queue through a valid/ready handshake. The block sits directly downstream of the CORDIC outputs and is the read side of that serial stream.

## Interface
Parameters:
- WIDTH, 16, word width in bits; must match the CORDIC WIDTH (≥2).

Ports:
- clk  in  1  rising-edge clock, shared with the CORDIC.
- rst_n  in  1  reset; asynchronous, active-low.
- valid_i  in  1  frame strobe from the CORDIC `valid`; high for exactly WIDTH cycles per result.
- xi  in  1  serial x result bit, LSB first.
- yi  in  1  serial y result bit, LSB first.
- zi  in  1  serial z result bit, LSB first.
- x_out  out  WIDTH  x word at the head of the queue.
- y_out  out  WIDTH  y word at the head of the queue.
- z_out  out  WIDTH  z word at the head of the queue.
- out_valid  out  1  queue non-empty; the head word is valid.
- out_ready  in  1  consumer accepts the head word.
- frame_err  out  1  one-cycle pulse; a frame ended short.
- overflow  out  1  sticky flag; a completed word was dropped because the queue was full.

## Operation
Bit counter and capture:
- Bit counter `cnt` runs 0..WIDTH-1.
- Each cycle with valid_i=1: shift {xi, sr_x[WIDTH-1:1]} into sr_x; y and z are handled the same way.
- When cnt==WIDTH-1 the word is complete. Push {xi, sr_x[WIDTH-1:1]} (likewise y, z) into the queue and wrap cnt to 0.
- If valid_i stays high past WIDTH cycles, the next bit starts a new word (back-to-back frames).
- If valid_i falls while cnt is 1..WIDTH-1:
  - discard the partial word;
  - cnt←0;
  - pulse frame_err for 1 cycle.
- valid_i low with cnt==0 is idle. Shift registers hold their value.

Queue:
- 2 entries, with registered read/write pointers and a count 0..2.
- Outputs x_out/y_out/z_out show the head entry. Their value is don't-care when out_valid=0, but the implementation drives the stored head value.
- Pop condition: out_valid & out_ready.
- Push while count<2: accepted.
- Push while count==2 and pop in the same cycle: accepted. Count stays 2 and order is preserved.
- Push while count==2 and no pop: word dropped, overflow←1. overflow stays set until reset.
- Pop with no push on an empty queue is impossible, because out_valid=0.
- Each word keeps x/y/z coherent (all from the same frame).

Reset (rst_n=0), asynchronous:
- cnt=0, shift registers=0, queue empty.
- out_valid=0, x_out/y_out/z_out=0, frame_err=0, overflow=0.
- Reset in the middle of a frame drops the partial word.
- After rst_n rises, capture starts at the next valid_i high, with that cycle treated as bit 0.

## Timing
- Bit i of a frame is sampled on the i-th rising edge (counting from 0) where valid_i=1.
- Word latency: out_valid rises on the edge after the last-bit cycle, i.e. WIDTH cycles after the first bit, provided the queue was empty.
- Throughput: one word per WIDTH cycles. A consumer holding out_ready=1 never causes overflow.
- out_valid deasserts on the edge after a pop that empties the queue.
- frame_err is asserted on the edge after the cycle where valid_i is first sampled low mid-frame, and lasts exactly 1 cycle.
- No combinational path from valid_i, xi, yi or zi to any output. out_ready affects state only (a registered pop).

## Test plan
- Single frame: drive x=0x26DD, y=0x0000, z=0xC90F LSB first over 16 valid cycles, out_ready=1 → out_valid high for 1 cycle, 16 cycles after the first bit, with x_out=0x26DD, y_out=0x0000, z_out=0xC90F.
- Back-to-back: 3 consecutive frames (valid_i high for 48 cycles) carrying x=0x0001, 0x8000, 0xFFFF, with out_ready=0 → queue holds 0x0001 and 0x8000, the third word is dropped, and overflow=1. Raising out_ready then yields 0x0001 followed by 0x8000; overflow stays 1.
- Full with simultaneous pop: queue full, out_ready=1 on the cycle the third word completes → no overflow, and words come out in order 1, 2, 3.
- Short frame: valid_i high for 9 cycles, then low → frame_err pulses once and no word is pushed. A following full frame with x=0x1234 delivers x_out=0x1234.
- Reset mid-frame: rst_n=0 after 7 bits → all outputs 0 immediately, with no clock edge needed. The next full frame with y=0xA5A5 delivers y_out=0xA5A5 and frame_err stays 0.
- Hold: out_valid=1 and out_ready=0 for 100 cycles with no new frames → outputs are stable and out_valid stays 1.
